rv_multicycle_controller: RTL and testbench
===========================================

Name: rv_multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle control unit. It decodes a latched 32-bit RISC-V instruction across FETCH/DECODE/EXEC/MEM/WB states and waits on memory handshakes.
- Generates XLEN-wide sign-extended immediates and a 4-bit ALU opcode covering the full RV32I/RV64I ALU set.
- Sits between instruction/data memory ports and the shared-ALU datapath. Counts retired instructions and traps on illegal opcodes.

Parameters:
- XLEN, 64, datapath/immediate width; legal values 32 or 64.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr  in  32  instruction word from instruction memory (bit 0 = LSB)
- instr_valid  in  1  instruction memory has valid data this cycle
- mem_ready  in  1  data memory completes access this cycle
- alu_zero  in  1  ALU result == 0
- ir_write  out  1  latch instr into datapath IR
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = ALU/branch target
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = imm
- alu_control  out  4  ALU operation
- imem_read  out  1  instruction fetch request
- mem_read  out  1  data load request
- mem_write  out  1  data store request
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = PC+4 (link)
- imm  out  XLEN  sign-extended immediate of latched instruction
- illegal  out  1  sticky trap flag
- instret  out  CNT_W  retired-instruction count
- state  out  3  current FSM state (debug)

Behaviour:
- Reset:
  - Async assert forces state = FETCH, internal IR = 32'h00000013 (NOP), illegal = 0, instret = 0.
  - All strobes are 0 while rst is high. Mid-operation reset abandons any pending memory access the same instant.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7. All strobes are Moore/registered-state decodes, except where noted as Mealy on a handshake input.
- FETCH:
  - imem_read = 1.
  - On instr_valid: ir_write = 1, pc_write = 1, pc_src = 0 (Mealy), IR <= instr, go to DECODE.
  - Otherwise hold FETCH indefinitely.
- DECODE: one cycle. If opcode[6:0] is not one of the supported set, go to TRAP; otherwise go to EXEC.
- Supported opcodes:
  - 0110011 R-ALU
  - 0010011 I-ALU
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH (funct3 000 BEQ, 001 BNE; other funct3 values are illegal)
  - 1101111 JAL
  - 0110111 LUI
- alu_control map:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
- alu_control derivation:
  - funct3 + instr[30] select the operation for R-ALU.
  - I-ALU uses the same mapping, except SUB never occurs; instr[30] only distinguishes SRAI from SRLI.
  - LOAD/STORE/JAL/LUI use ADD. BRANCH uses SUB.
- EXEC:
  - R-ALU: alu_src_b = 0; go to WB.
  - I-ALU/LOAD/STORE: alu_src_b = 1. I-ALU goes to WB; LOAD/STORE go to MEM.
  - LUI: alu_src_b = 1, rs1 forced to zero by the datapath; go to WB.
  - BRANCH: taken = (BEQ & alu_zero) | (BNE & !alu_zero).
    - If taken: pc_write = 1, pc_src = 1.
    - instret increments; go to FETCH.
  - JAL: alu_src_a = 1, alu_src_b = 1, pc_write = 1, pc_src = 1; go to WB. The datapath holds the old PC+4 for the link.
- MEM:
  - LOAD: mem_read = 1 until mem_ready, then go to WB.
  - STORE: mem_write = 1 until mem_ready, then instret++ and go to FETCH.
  - Strobes stay asserted continuously while waiting; a ready in the first MEM cycle gives single-cycle access.
- WB:
  - reg_write = 1; wb_sel = 01 for LOAD, 10 for JAL, 00 otherwise.
  - instret++; go to FETCH.
  - Writes to rd = x0 still assert reg_write; the register file ignores them.
- TRAP:
  - illegal = 1, all strobes 0; remain until reset.
  - No instret increment for the trapping instruction.
- Immediates: combinational from IR, sign-extended from instr[31] to XLEN.
  - I-type: [31:20]
  - S-type: {[31:25],[11:7]}
  - B-type: {[31],[7],[30:25],[11:8],0}
  - J-type: {[31],[19:12],[20],[30:21],0}
  - U-type: {[31:12],12'b0}, sign-extended for XLEN = 64
  - R-type: imm = 0
- instret: wraps modulo 2^CNT_W without flag.
- Latency (cycles, with zero memory waits):
  - ALU/LUI: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH: 3
  - JAL: 4

Test Plan:
- Reset mid-MEM wait of a LOAD (mem_ready held 0) -> state = 0, mem_read = 0, instret = 0 immediately on rst rise; after release, imem_read = 1.
- ADDI x1,x0,-1 (32'hFFF00093), instr_valid at cycle 1, XLEN = 64 -> imm = 64'hFFFF_FFFF_FFFF_FFFF, alu_control = 0000, alu_src_b = 1; reg_write in WB 4 cycles after fetch; instret = 1.
- LW with mem_ready delayed 3 cycles -> mem_read high for exactly 4 consecutive cycles; then WB with wb_sel = 01; instret +1.
- BEQ, imm = -8: once with alu_zero = 1 -> pc_write & pc_src = 1 in EXEC; once with alu_zero = 0 -> pc_write = 0; both return to FETCH after 3 cycles with instret incremented.
- SRAI (instr[30] = 1, funct3 101) -> alu_control = 0111. SUB R-type -> 0001.
- Opcode 7'b1111111 -> DECODE goes to TRAP; illegal = 1 persists 100 cycles despite instr_valid; instret unchanged; cleared only by rst.

Source files
------------

// File: rtl/rv_multicycle_controller.sv
// Multi-cycle RV32I/RV64I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshakes,
// immediate generation, ALU opcode decode, retired-instruction counting and an illegal-opcode trap.
module rv_multicycle_controller #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [3:0]       alu_control,
  output logic             imem_read,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  state_t           cur_state, nxt_state;
  logic [ILEN-1:0]  ir;
  logic [CNT_W-1:0] count;
  logic             retire;
  logic             supported;
  logic             taken;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [ILEN-1:0]  imm32;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign taken  = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);

  // Opcode legality; only BEQ/BNE are implemented among branches
  always_comb begin
    supported = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_LUI: supported = 1'b1;
      OP_BRANCH: supported = (funct3 == 3'b000) || (funct3 == 3'b001);
      default:   supported = 1'b0;
    endcase
  end

  // ALU opcode; instr[30] selects SUB only for register-register forms
  always_comb begin
    alu_control = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          3'b000:  alu_control = (opcode == OP_R && ir[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ir[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      OP_BRANCH: alu_control = ALU_SUB;
      default:   alu_control = ALU_ADD;
    endcase
  end

  // Immediate assembled at 32 bits, then sign-extended to XLEN
  always_comb begin
    case (opcode)
      OP_I, OP_LOAD: imm32 = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:      imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:     imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:        imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_LUI:        imm32 = {ir[31:12], 12'b0};
      default:       imm32 = '0;
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign illegal = (cur_state == TRAP);
  assign instret = count;
  assign state   = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= FETCH;
      ir        <= NOP;
      count     <= '0;
    end else begin
      cur_state <= nxt_state;
      if (ir_write) ir <= instr;
      if (retire)   count <= count + CNT_W'(1);
    end
  end

  // Next state and strobes; everything is forced quiet while reset is held
  always_comb begin
    nxt_state = cur_state;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    imem_read = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    retire    = 1'b0;
    if (!rst) begin
      case (cur_state)
        FETCH: begin
          imem_read = 1'b1;
          if (instr_valid) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            nxt_state = DECODE;
          end
        end
        DECODE: nxt_state = supported ? EXEC : TRAP;
        EXEC: begin
          case (opcode)
            OP_R: nxt_state = WB;
            OP_I, OP_LUI: begin
              alu_src_b = 1'b1;
              nxt_state = WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_b = 1'b1;
              nxt_state = MEM;
            end
            OP_BRANCH: begin
              pc_write  = taken;
              pc_src    = taken;
              retire    = 1'b1;
              nxt_state = FETCH;
            end
            OP_JAL: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              pc_write  = 1'b1;
              pc_src    = 1'b1;
              nxt_state = WB;
            end
            default: nxt_state = TRAP;
          endcase
        end
        MEM: begin
          if (opcode == OP_STORE) begin
            mem_write = 1'b1;
            if (mem_ready) begin
              retire    = 1'b1;
              nxt_state = FETCH;
            end
          end else begin
            mem_read = 1'b1;
            if (mem_ready) nxt_state = WB;
          end
        end
        WB: begin
          reg_write = 1'b1;
          if (opcode == OP_LOAD)     wb_sel = 2'b01;
          else if (opcode == OP_JAL) wb_sel = 2'b10;
          retire    = 1'b1;
          nxt_state = FETCH;
        end
        TRAP:    nxt_state = TRAP;
        default: nxt_state = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// Directed bench for rv_multicycle_controller (XLEN=64): walks each instruction class through the FSM
// and compares strobes, immediates, ALU opcode and instret against hand-computed values.
module tb_rv_multicycle_controller;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_ready;
  logic        alu_zero;
  logic        ir_write, pc_write, pc_src, alu_src_a, alu_src_b;
  logic [3:0]  alu_control;
  logic        imem_read, mem_read, mem_write, reg_write;
  logic [1:0]  wb_sel;
  logic [63:0] imm;
  logic        illegal;
  logic [31:0] instret;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  rv_multicycle_controller #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imem_read(imem_read),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .imm(imm), .illegal(illegal), .instret(instret),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 2 time units after the rising edge
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  // Present an instruction in FETCH, check the Mealy handshake, then land in DECODE
  task automatic fetch(input logic [31:0] word);
    instr       = word;
    instr_valid = 1'b1;
    #1;
    chk("fetch_ir_write", 64'(ir_write), 64'h1);
    chk("fetch_pc_write", 64'(pc_write), 64'h1);
    chk("fetch_pc_src",   64'(pc_src),   64'h0);
    next();
    instr_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; instr = '0; instr_valid = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state",   64'(state),     64'h0);
    chk("rst_imem",    64'(imem_read), 64'h0);
    chk("rst_instret", 64'(instret),   64'h0);
    chk("rst_illegal", 64'(illegal),   64'h0);
    chk("rst_imm_nop", imm,            64'h0);
    rst = 1'b0;
    #1;
    chk("fetch_imem", 64'(imem_read), 64'h1);

    // ADDI x1,x0,-1
    fetch(32'hFFF0_0093);
    chk("addi_dec_state", 64'(state),       64'h1);
    chk("addi_imm",       imm,              64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_aluc",      64'(alu_control), 64'h0);
    next();
    chk("addi_exec_state", 64'(state),     64'h2);
    chk("addi_src_b",      64'(alu_src_b), 64'h1);
    next();
    chk("addi_wb_state", 64'(state),     64'h4);
    chk("addi_reg_write", 64'(reg_write), 64'h1);
    chk("addi_wb_sel",   64'(wb_sel),    64'h0);
    next();
    chk("addi_back_fetch", 64'(state),   64'h0);
    chk("addi_instret",    64'(instret), 64'h1);

    // LW x2,0(x1) with three wait cycles
    fetch(32'h0000_A103);
    next();
    chk("lw_src_b", 64'(alu_src_b), 64'h1);
    next();
    n = 0;
    for (int i = 0; i < 10 && state == 3'd3; i++) begin
      if (mem_read) n++;
      if (n == 4) mem_ready = 1'b1;
      next();
    end
    mem_ready = 1'b0;
    chk("lw_mem_cycles", 64'(n),         64'h4);
    chk("lw_wb_state",   64'(state),     64'h4);
    chk("lw_wb_sel",     64'(wb_sel),    64'h1);
    chk("lw_reg_write",  64'(reg_write), 64'h1);
    chk("lw_rd_drop",    64'(mem_read),  64'h0);
    next();
    chk("lw_instret", 64'(instret), 64'h2);

    // BEQ x1,x2,-8 taken
    fetch(32'hFE20_8CE3);
    chk("beq_imm",  imm,              64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_aluc", 64'(alu_control), 64'h1);
    alu_zero = 1'b1;
    next();
    chk("beq_t_state",    64'(state),    64'h2);
    chk("beq_t_pc_write", 64'(pc_write), 64'h1);
    chk("beq_t_pc_src",   64'(pc_src),   64'h1);
    next();
    chk("beq_t_fetch",   64'(state),   64'h0);
    chk("beq_t_instret", 64'(instret), 64'h3);

    // BEQ not taken
    fetch(32'hFE20_8CE3);
    alu_zero = 1'b0;
    next();
    chk("beq_n_pc_write", 64'(pc_write), 64'h0);
    chk("beq_n_pc_src",   64'(pc_src),   64'h0);
    next();
    chk("beq_n_fetch",   64'(state),   64'h0);
    chk("beq_n_instret", 64'(instret), 64'h4);

    // SRAI x3,x1,3
    fetch(32'h4030_D193);
    chk("srai_aluc", 64'(alu_control), 64'h7);
    chk("srai_imm",  imm,              64'h403);
    next(); next(); next();
    chk("srai_instret", 64'(instret), 64'h5);

    // SUB x3,x1,x2
    fetch(32'h4020_81B3);
    chk("sub_aluc", 64'(alu_control), 64'h1);
    chk("sub_imm",  imm,              64'h0);
    next();
    chk("sub_src_b", 64'(alu_src_b), 64'h0);
    next(); next();
    chk("sub_instret", 64'(instret), 64'h6);

    // LUI x5,0x80000
    fetch(32'h8000_02B7);
    chk("lui_imm",  imm,              64'hFFFF_FFFF_8000_0000);
    chk("lui_aluc", 64'(alu_control), 64'h0);
    next();
    chk("lui_src_b", 64'(alu_src_b), 64'h1);
    next(); next();
    chk("lui_instret", 64'(instret), 64'h7);

    // JAL x1,-4
    fetch(32'hFFDF_F0EF);
    chk("jal_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    next();
    chk("jal_src_a",    64'(alu_src_a), 64'h1);
    chk("jal_pc_write", 64'(pc_write),  64'h1);
    chk("jal_pc_src",   64'(pc_src),    64'h1);
    next();
    chk("jal_wb_sel",    64'(wb_sel),    64'h2);
    chk("jal_reg_write", 64'(reg_write), 64'h1);
    next();
    chk("jal_instret", 64'(instret), 64'h8);

    // SW x2,8(x1) with immediate ready
    fetch(32'h0020_A423);
    chk("sw_imm", imm, 64'h8);
    next();
    chk("sw_src_b", 64'(alu_src_b), 64'h1);
    next();
    mem_ready = 1'b1;
    chk("sw_mem_state", 64'(state),     64'h3);
    chk("sw_mem_write", 64'(mem_write), 64'h1);
    chk("sw_no_read",   64'(mem_read),  64'h0);
    next();
    mem_ready = 1'b0;
    chk("sw_fetch",   64'(state),     64'h0);
    chk("sw_wr_drop", 64'(mem_write), 64'h0);
    chk("sw_instret", 64'(instret),   64'h9);

    // Illegal opcode 1111111 traps and sticks
    fetch(32'h0000_007F);
    chk("trap_dec_state", 64'(state), 64'h1);
    next();
    chk("trap_state",   64'(state),   64'h7);
    chk("trap_illegal", 64'(illegal), 64'h1);
    instr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      next();
      chk("trap_hold_illegal", 64'(illegal),  64'h1);
      chk("trap_hold_irw",     64'(ir_write), 64'h0);
    end
    instr_valid = 1'b0;
    chk("trap_instret", 64'(instret), 64'h9);
    rst = 1'b1;
    #1;
    chk("trap_rst_illegal", 64'(illegal), 64'h0);
    next();
    rst = 1'b0;
    #1;
    chk("trap_rst_state", 64'(state), 64'h0);

    // Reset while a load waits on memory
    fetch(32'hFFF0_0093);
    next(); next(); next();
    fetch(32'h0000_A103);
    next(); next();
    chk("rstmem_state",   64'(state),    64'h3);
    chk("rstmem_read",    64'(mem_read), 64'h1);
    chk("rstmem_pre_cnt", 64'(instret),  64'h1);
    rst = 1'b1;
    #1;
    chk("rstmem_now_state", 64'(state),     64'h0);
    chk("rstmem_now_read",  64'(mem_read),  64'h0);
    chk("rstmem_now_cnt",   64'(instret),   64'h0);
    chk("rstmem_now_imem",  64'(imem_read), 64'h0);
    next();
    rst = 1'b0;
    #1;
    chk("rstmem_rel_imem", 64'(imem_read), 64'h1);

    // Branch with unsupported funct3 traps
    fetch(32'h0020_A063);
    next();
    chk("bad_br_state",   64'(state),   64'h7);
    chk("bad_br_illegal", 64'(illegal), 64'h1);
    chk("bad_br_instret", 64'(instret), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
